// File: rtl/calc2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc2_pkg
// Brief    : Shared widths, command/response codes and request FIFO entry
//            type for the calc2 port driver.
// Revision : 1.0 - initial release
// ============================================================================
package calc2_pkg;

    localparam int DATA_W   = 32;
    localparam int CMD_W    = 4;
    localparam int TAG_W    = 2;
    localparam int NUM_TAGS = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_TMO  = 2'd3
    } resp_e;

    // cmd is kept as raw bits so unknown commands pass through untouched
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } fifo_entry_t;

    function automatic logic [TAG_W-1:0] lowest_clear_bit(input logic [NUM_TAGS-1:0] vec);
        logic [TAG_W-1:0] idx;
        idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!vec[i]) idx = TAG_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc2_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : calc2_req_fifo
// Brief    : Synchronous request FIFO with occupancy count; head is shown
//            combinationally, pointers wrap modulo DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module calc2_req_fifo
    import calc2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  fifo_entry_t            i_data,
    input  logic                   i_pop,
    output fifo_entry_t            o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    fifo_entry_t        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_wr_en;
    logic               w_rd_en;

    assign o_full  = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc2_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : calc2_port_driver
// Brief    : calc2 request port: queues operations, allocates tags, issues the
//            two-cycle command/operand protocol and retires tags on responses.
// Options  : RESP_TIMEOUT_EN - per-tag response watchdog (TIMEOUT_CYCLES)
// Revision : 1.0 - initial release
// ============================================================================
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_W-1:0]    req_cmd,
    input  logic [DATA_W-1:0]   req_op1,
    input  logic [DATA_W-1:0]   req_op2,
    output logic [CMD_W-1:0]    cmd_out,
    output logic [DATA_W-1:0]   data_out,
    output logic [TAG_W-1:0]    tag_out,
    input  logic [1:0]          resp_in,
    input  logic [DATA_W-1:0]   resp_data_in,
    input  logic [TAG_W-1:0]    resp_tag_in,
    output logic                cpl_valid,
    output logic [1:0]          cpl_resp,
    output logic [DATA_W-1:0]   cpl_data,
    output logic [TAG_W-1:0]    cpl_tag,
    output logic [NUM_TAGS-1:0] busy_tags,
    output logic                spurious_resp,
    output logic                timeout_err
);

    localparam int         c_cnt_w   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_op1  = 2'd1;
    localparam logic [1:0] c_st_op2  = 2'd2;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_param_check
        $error("calc2_port_driver: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_alloc;
    logic [c_cnt_w-1:0]  w_count;
    fifo_entry_t         w_wr_entry;
    fifo_entry_t         w_head;
    logic [NUM_TAGS-1:0] r_busy_tags;
    logic [NUM_TAGS-1:0] w_set_mask;
    logic [NUM_TAGS-1:0] w_clr_mask;
    logic [NUM_TAGS-1:0] w_tmo_clr_mask;
    logic                w_free_exists;
    logic [TAG_W-1:0]    w_alloc_tag;
    logic                w_resp_hit;
    logic                w_resp_retire;
    logic                w_resp_spur;
    logic                w_tmo_fire;
    logic [TAG_W-1:0]    w_tmo_tag;
    logic                w_cpl_fire;
    logic                r_cpl_valid;
    logic [1:0]          r_cpl_resp;
    logic [DATA_W-1:0]   r_cpl_data;
    logic [TAG_W-1:0]    r_cpl_tag;
    logic                r_spurious;

    assign req_ready  = !w_full;
    assign w_push     = req_valid && !w_full;
    assign w_wr_entry = {req_cmd, req_op1, req_op2};

    calc2_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .i_clk   (c_clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_free_exists = ~&r_busy_tags;
    assign w_alloc_tag   = lowest_clear_bit(r_busy_tags);

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    // An entry being pushed this cycle is visible at the FIFO head next cycle
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_alloc      = 1'b0;
        cmd_out      = '0;
        data_out     = '0;
        tag_out      = '0;
        case (r_state)
            c_st_idle: begin
                if ((!w_empty || w_push) && w_free_exists) w_state_next = c_st_op1;
            end
            c_st_op1: begin
                cmd_out      = w_head.cmd;
                data_out     = w_head.op1;
                tag_out      = w_alloc_tag;
                w_alloc      = 1'b1;
                w_state_next = c_st_op2;
            end
            c_st_op2: begin
                data_out = w_head.op2;
                w_pop    = 1'b1;
                if (((w_count > c_cnt_w'(1)) || w_push) && w_free_exists)
                    w_state_next = c_st_op1;
                else
                    w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    assign w_resp_hit    = (resp_in != 2'b00);
    assign w_resp_retire = w_resp_hit && r_busy_tags[resp_tag_in];
    assign w_resp_spur   = w_resp_hit && !r_busy_tags[resp_tag_in];

`ifdef RESP_TIMEOUT_EN
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

    logic [NUM_TAGS-1:0] w_tmo_hit;
    logic                r_timeout_err;

    // Counters saturate at the limit so a deferred expiry is not lost
    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tmo
        logic [7:0] r_tmo_cnt;
        assign w_tmo_hit[g] = r_busy_tags[g] && (r_tmo_cnt == c_tmo_last);
        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset)                                r_tmo_cnt <= '0;
            else if (w_set_mask[g])                    r_tmo_cnt <= '0;
            else if (r_busy_tags[g] && !w_tmo_hit[g])  r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // A real response owns the completion slot; expiry waits a cycle
    assign w_tmo_fire = (|w_tmo_hit) && !w_resp_retire;
    assign w_tmo_tag  = lowest_clear_bit(~w_tmo_hit);

    always_comb begin
        w_tmo_clr_mask = '0;
        if (w_tmo_fire) w_tmo_clr_mask[w_tmo_tag] = 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) r_timeout_err <= 1'b0;
        else        r_timeout_err <= w_tmo_fire;
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_fire     = 1'b0;
    assign w_tmo_tag      = '0;
    assign w_tmo_clr_mask = '0;
    assign timeout_err    = 1'b0;
`endif

    assign w_cpl_fire = w_resp_retire || w_tmo_fire;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = w_tmo_clr_mask;
        if (w_alloc)       w_set_mask[w_alloc_tag] = 1'b1;
        if (w_resp_retire) w_clr_mask[resp_tag_in] = 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_busy_tags <= '0;
            r_cpl_valid <= 1'b0;
            r_cpl_resp  <= '0;
            r_cpl_data  <= '0;
            r_cpl_tag   <= '0;
            r_spurious  <= 1'b0;
        end else begin
            r_busy_tags <= (r_busy_tags & ~w_clr_mask) | w_set_mask;
            r_cpl_valid <= w_cpl_fire;
            r_spurious  <= w_resp_spur;
            if (w_cpl_fire) begin
                r_cpl_resp <= w_resp_retire ? resp_in      : RESP_TMO;
                r_cpl_data <= w_resp_retire ? resp_data_in : '0;
                r_cpl_tag  <= w_resp_retire ? resp_tag_in  : w_tmo_tag;
            end
        end
    end

    assign busy_tags     = r_busy_tags;
    assign cpl_valid     = r_cpl_valid;
    assign cpl_resp      = r_cpl_resp;
    assign cpl_data      = r_cpl_data;
    assign cpl_tag       = r_cpl_tag;
    assign spurious_resp = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_calc2_port_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_calc2_port_driver
// Brief    : Directed self-checking bench for calc2_port_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc2_port_driver;
    import calc2_pkg::*;

`ifdef RESP_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic [1:0]  resp_in = '0;
    logic [31:0] resp_data_in = '0;
    logic [1:0]  resp_tag_in = '0;
    logic        req_ready;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  tag_out;
    logic        cpl_valid;
    logic [1:0]  cpl_resp;
    logic [31:0] cpl_data;
    logic [1:0]  cpl_tag;
    logic [3:0]  busy_tags;
    logic        spurious_resp;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 c_clk = ~c_clk;

    calc2_port_driver #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .cmd_out       (cmd_out),
        .data_out      (data_out),
        .tag_out       (tag_out),
        .resp_in       (resp_in),
        .resp_data_in  (resp_data_in),
        .resp_tag_in   (resp_tag_in),
        .cpl_valid     (cpl_valid),
        .cpl_resp      (cpl_resp),
        .cpl_data      (cpl_data),
        .cpl_tag       (cpl_tag),
        .busy_tags     (busy_tags),
        .spurious_resp (spurious_resp),
        .timeout_err   (timeout_err)
    );

    task automatic start_cycle();
        @(posedge c_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge c_clk);
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_cmd      = '0;
        req_op1      = '0;
        req_op2      = '0;
        resp_in      = '0;
        resp_data_in = '0;
        resp_tag_in  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b1;
    endtask

    task automatic push(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = a;
        req_op2   = b;
    endtask

    task automatic test_reset();
        logic [80:0] outs;
        idle_inputs();
        reset = 1'b0;
        sample();
        outs = {cmd_out, data_out, tag_out, busy_tags, cpl_valid, cpl_resp, cpl_data, cpl_tag,
                spurious_resp, timeout_err};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        @(posedge c_clk);
        #1 reset = 1'b1;
        sample();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++;
        if (busy_tags !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy_tags); end
        start_cycle();
    endtask

    task automatic test_single_add();
        do_reset();
        push(CMD_ADD, 32'd5, 32'd7);
        sample();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", req_ready); end
        checks++;
        if (cmd_out !== 4'd0) begin errors++; $display("FAIL add_no_bypass: got %0d expected 0", cmd_out); end
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if ({cmd_out, data_out, tag_out} !== {4'd1, 32'd5, 2'd0}) begin
            errors++; $display("FAIL add_op1: got cmd=%0d data=%0d tag=%0d expected 1/5/0", cmd_out, data_out, tag_out);
        end
        start_cycle();
        sample();
        checks++;
        if ({cmd_out, data_out, tag_out} !== {4'd0, 32'd7, 2'd0}) begin
            errors++; $display("FAIL add_op2: got cmd=%0d data=%0d tag=%0d expected 0/7/0", cmd_out, data_out, tag_out);
        end
        checks++;
        if (busy_tags !== 4'b0001) begin errors++; $display("FAIL add_busy: got %b expected 0001", busy_tags); end
        start_cycle();
        resp_in = 2'd1; resp_data_in = 32'd12; resp_tag_in = 2'd0;
        sample();
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if ({cpl_valid, cpl_resp, cpl_data, cpl_tag} !== {1'b1, 2'd1, 32'd12, 2'd0}) begin
            errors++; $display("FAIL add_cpl: got v=%b r=%0d d=%0d t=%0d expected 1/1/12/0", cpl_valid, cpl_resp, cpl_data, cpl_tag);
        end
        checks++;
        if (busy_tags !== 4'b0000) begin errors++; $display("FAIL add_retire: got %b expected 0000", busy_tags); end
        start_cycle();
        sample();
        checks++;
        if (cpl_valid !== 1'b0) begin errors++; $display("FAIL add_cpl_pulse: got %b expected 0", cpl_valid); end
        start_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cmds [6];
        logic [1:0]  iss_tag [8];
        logic [3:0]  iss_cmd [8];
        logic [31:0] iss_data [8];
        int          iss_cyc [8];
        int          k;
        int          n_iss;
        cmds  = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2};
        k     = 0;
        n_iss = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (k < 6) push(cmds[k], 32'h100 + 32'(k), 32'h200 + 32'(k));
            else       req_valid = 1'b0;
            sample();
            if (cmd_out !== 4'd0 && n_iss < 8) begin
                iss_tag[n_iss] = tag_out; iss_cmd[n_iss] = cmd_out;
                iss_data[n_iss] = data_out; iss_cyc[n_iss] = c;
                n_iss++;
            end
            if (req_valid && req_ready) k++;
            start_cycle();
        end
        req_valid = 1'b0;
        checks++;
        if (k !== 6) begin errors++; $display("FAIL b2b_accepted: got %0d expected 6", k); end
        checks++;
        if (n_iss !== 4) begin errors++; $display("FAIL b2b_issue_count: got %0d expected 4", n_iss); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (iss_tag[i] !== 2'(i) || iss_cmd[i] !== cmds[i] || iss_data[i] !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL b2b_issue[%0d]: got tag=%0d cmd=%0d data=%h expected tag=%0d cmd=%0d data=%h",
                                   i, iss_tag[i], iss_cmd[i], iss_data[i], i, cmds[i], 32'h100 + 32'(i));
            end
            checks++;
            if (iss_cyc[i] - iss_cyc[0] !== 2 * i) begin
                errors++; $display("FAIL b2b_slot[%0d]: got offset %0d expected %0d", i, iss_cyc[i] - iss_cyc[0], 2 * i);
            end
        end
        sample();
        checks++;
        if (busy_tags !== 4'b1111 || cmd_out !== 4'd0) begin
            errors++; $display("FAIL b2b_hold: got busy=%b cmd=%0d expected 1111/0", busy_tags, cmd_out);
        end
        start_cycle();
        // two entries remain queued; two more fill the FIFO
        for (int j = 0; j < 2; j++) begin
            push(4'd1, 32'h300 + 32'(j), 32'h400 + 32'(j));
            sample();
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_fill_ready[%0d]: got %b expected 1", j, req_ready); end
            start_cycle();
        end
        req_valid = 1'b0;
        sample();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b expected 0", req_ready); end
        start_cycle();
        resp_in = 2'd1; resp_data_in = 32'h55; resp_tag_in = 2'd2;
        sample();
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if (cpl_valid !== 1'b1 || cpl_tag !== 2'd2 || busy_tags !== 4'b1011) begin
            errors++; $display("FAIL b2b_retire2: got v=%b tag=%0d busy=%b expected 1/2/1011", cpl_valid, cpl_tag, busy_tags);
        end
        start_cycle();
        sample();
        checks++;
        if ({cmd_out, data_out, tag_out} !== {cmds[4], 32'h104, 2'd2}) begin
            errors++; $display("FAIL b2b_reuse: got cmd=%0d data=%h tag=%0d expected %0d/104/2", cmd_out, data_out, tag_out, cmds[4]);
        end
        start_cycle();
    endtask

    task automatic test_spurious();
        do_reset();
        push(CMD_ADD, 32'd3, 32'd4);
        sample(); start_cycle();
        idle_inputs();
        sample(); start_cycle();
        sample(); start_cycle();
        resp_in = 2'd1; resp_data_in = 32'd9; resp_tag_in = 2'd3;
        sample();
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if (spurious_resp !== 1'b1) begin errors++; $display("FAIL spur_pulse: got %b expected 1", spurious_resp); end
        checks++;
        if (cpl_valid !== 1'b0) begin errors++; $display("FAIL spur_no_cpl: got %b expected 0", cpl_valid); end
        checks++;
        if (busy_tags !== 4'b0001) begin errors++; $display("FAIL spur_busy: got %b expected 0001", busy_tags); end
        start_cycle();
        sample();
        checks++;
        if (spurious_resp !== 1'b0) begin errors++; $display("FAIL spur_one_cycle: got %b expected 0", spurious_resp); end
        start_cycle();
    endtask

    task automatic test_invalid_cmd();
        do_reset();
        push(4'd4, 32'hA, 32'hB);
        sample(); start_cycle();
        idle_inputs();
        sample();
        checks++;
        if ({cmd_out, data_out, tag_out} !== {4'd4, 32'hA, 2'd0}) begin
            errors++; $display("FAIL inv_issue: got cmd=%0d data=%h tag=%0d expected 4/a/0", cmd_out, data_out, tag_out);
        end
        start_cycle();
        sample(); start_cycle();
        resp_in = 2'd2; resp_data_in = 32'd0; resp_tag_in = 2'd0;
        sample();
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if ({cpl_valid, cpl_resp, cpl_tag} !== {1'b1, 2'd2, 2'd0}) begin
            errors++; $display("FAIL inv_cpl: got v=%b r=%0d t=%0d expected 1/2/0", cpl_valid, cpl_resp, cpl_tag);
        end
        start_cycle();
    endtask

    task automatic test_reset_mid_op();
        logic [80:0] outs;
        int          n_iss;
        do_reset();
        push(CMD_SUB, 32'h20, 32'h10);
        sample(); start_cycle();
        idle_inputs();
        sample(); start_cycle();
        sample();
        checks++;
        if (data_out !== 32'h10) begin errors++; $display("FAIL rst_mid_op2: got %h expected 10", data_out); end
        #1 reset = 1'b0;
        #1;
        outs = {cmd_out, data_out, tag_out, busy_tags, cpl_valid, cpl_resp, cpl_data, cpl_tag,
                spurious_resp, timeout_err};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        @(posedge c_clk);
        @(posedge c_clk);
        #1 reset = 1'b1;
        sample();
        checks++;
        if (req_ready !== 1'b1 || busy_tags !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_after: got ready=%b busy=%b expected 1/0000", req_ready, busy_tags);
        end
        n_iss = 0;
        for (int c = 0; c < 4; c++) begin
            if (cmd_out !== 4'd0 || data_out !== 32'd0) n_iss++;
            start_cycle();
            sample();
        end
        checks++;
        if (n_iss !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d issue cycles expected 0", n_iss); end
        start_cycle();
    endtask

`ifdef RESP_TIMEOUT_EN
    task automatic test_timeout();
        int         hit_cyc;
        logic [6:0] snap;
        do_reset();
        push(CMD_ADD, 32'd1, 32'd2);
        sample(); start_cycle();
        idle_inputs();
        sample();
        checks++;
        if (cmd_out !== 4'd1 || tag_out !== 2'd0) begin
            errors++; $display("FAIL tmo_issue: got cmd=%0d tag=%0d expected 1/0", cmd_out, tag_out);
        end
        start_cycle();
        hit_cyc = -1;
        snap    = '0;
        for (int c = 1; c < 40 && hit_cyc < 0; c++) begin
            sample();
            if (timeout_err === 1'b1) begin
                hit_cyc = c;
                snap    = {cpl_valid, cpl_resp, cpl_tag, busy_tags[1:0]};
            end
            start_cycle();
        end
        // busy for TMO cycles after the OP1 cycle, pulse registered one cycle later
        checks++;
        if (hit_cyc !== TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", hit_cyc, TMO + 1); end
        checks++;
        if (snap !== {1'b1, 2'd3, 2'd0, 2'b00}) begin
            errors++; $display("FAIL tmo_cpl: got v/resp/tag/busy=%b expected 1_11_00_00", snap);
        end
        sample();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", timeout_err); end
        resp_in = 2'd1; resp_data_in = 32'd3; resp_tag_in = 2'd0;
        start_cycle();
        idle_inputs();
        sample();
        checks++;
        if (spurious_resp !== 1'b1 || cpl_valid !== 1'b0) begin
            errors++; $display("FAIL tmo_late_resp: got spur=%b cpl=%b expected 1/0", spurious_resp, cpl_valid);
        end
        start_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_spurious();
        test_invalid_cmd();
        test_reset_mid_op();
`ifdef RESP_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
